// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the seven-segment scan controller.
//   NUM_DIGITS : number of multiplexed digits driven by the controller
//   SEG_BLANK  : active-low pattern with every segment off
//   SEG_TABLE  : active-low segment patterns for hex 0..F, bit order g..a
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index is the hex value; bit 6 = g ... bit 0 = a, 0 = segment lit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if -- valid/ready word handshake into the scan controller.
//   data_in    : four hex nibbles, nibble 0 is the rightmost digit
//   data_valid : producer offers data_in this cycle
//   data_ready : controller can take data_in this cycle
// Modports: master = producer side, slave = controller side.
interface display_scan_ctrl_if;

  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7 -- combinational hex-to-seven-segment decoder.
//   hex : 4-bit value to show
//   seg : active-low segments, bit order g..a
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl -- multiplexed 4-digit seven-segment scan controller.
// A prescaler splits time into digit slots of REFRESH_DIV cycles; each slot
// opens with BLANK_CYCLES of anode dead time. New words are taken through a
// one-deep pending register and only copied to the display on a frame
// boundary (digit_sel 3->0), so a frame never mixes two words.
// Ports:
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : display_scan_ctrl_if.slave (data_in/data_valid/data_ready)
//   anode     : active-low digit enables
//   cathode   : active-low segments g..a (registered)
//   digit_sel : current slot index (debug)
// Build option: define LEADING_ZERO_BLANK_EN to keep digits above the highest
// nonzero nibble dark (digit 0 is always shown).
// BLANK_CYCLES must be at least 1: the decoder output lags digit_sel by one
// cycle and that cycle is hidden inside the dead time.
module display_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  display_scan_ctrl_if.slave  bus,
  output logic [3:0]          anode,
  output logic [6:0]          cathode,
  output logic [1:0]          digit_sel
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
  localparam logic [1:0]    LAST_DIGIT = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] prescaler;
  logic [CW-1:0] prescaler_next;
  logic [1:0]    sel_next;
  logic [15:0]   display;
  logic [15:0]   display_next;
  logic [15:0]   pending;
  logic          pending_full;
  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic [3:0]    anode_next;
  logic [6:0]    cathode_next;
  logic [6:0]    seg_out;
  logic [NUM_DIGITS-1:0] shown;

  assign bus.data_ready = !pending_full;
  assign accept         = bus.data_valid && !pending_full;

  assign slot_end  = (prescaler == LAST_COUNT);
  assign frame_end = slot_end && (digit_sel == LAST_DIGIT);

  // Per-digit visibility, evaluated on the value the display will hold next
  // cycle so a frame-boundary load affects blanking from its first cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_shown
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign shown[gi] = 1'b1;
      end else begin : g_upper
        assign shown[gi] = |display_next[15:4*gi];
      end
`else
      assign shown[gi] = 1'b1;
`endif
    end
  endgenerate

  hex_to_seg7 u_dec (
    .hex (display[4*digit_sel +: 4]),
    .seg (seg_out)
  );

  always_comb begin
    prescaler_next = slot_end ? '0 : prescaler + 1'b1;
    sel_next       = slot_end ? digit_sel + 2'd1 : digit_sel;
    display_next   = (frame_end && pending_full) ? pending : display;

    // Anode is registered from next-state values so it lines up exactly with
    // the prescaler/digit_sel it belongs to.
    if ((prescaler_next < BLANK_END) || !shown[sel_next]) begin
      anode_next = 4'hF;
    end else begin
      anode_next = ~(4'b0001 << sel_next);
    end

    // Decoder sees the current digit_sel, giving one cycle of latency that
    // always lands inside the dead time of a fresh slot.
    cathode_next = (anode_next == 4'hF) ? SEG_BLANK : seg_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler    <= '0;
      digit_sel    <= 2'd0;
      display      <= 16'h0000;
      pending      <= 16'h0000;
      pending_full <= 1'b0;
      anode        <= 4'hF;
      cathode      <= SEG_BLANK;
    end else begin
      prescaler <= prescaler_next;
      digit_sel <= sel_next;
      display   <= display_next;
      anode     <= anode_next;
      cathode   <= cathode_next;
      if (accept) begin
        pending <= bus.data_in;
      end
      // On a frame boundary the pending word moves to the display; a word
      // taken in that same cycle (only possible if we were already empty)
      // refills the slot.
      if (frame_end) begin
        pending_full <= accept;
      end else if (accept) begin
        pending_full <= 1'b1;
      end
    end
  end

endmodule
